load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 37 +++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access size
// encoding, the legal XLEN set and per-size lane masks.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RSP    = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } lsu_size_e;

    localparam int unsigned XLEN_NARROW = 32;
    localparam int unsigned XLEN_WIDE   = 64;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == XLEN_NARROW) || (xlen == XLEN_WIDE);
    endfunction

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] size_mask(input lsu_size_e sz);
        case (sz)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            SZ_WORD: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_low_bits(input lsu_size_e sz);
        case (sz)
            SZ_BYTE: return 3'b000;
            SZ_HALF: return 3'b001;
            SZ_WORD: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data alignment: shifts the addressed bytes down to bit 0,
// truncates to the access size and sign- or zero-extends to XLEN.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           rdata,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  lsu_size_e                 size,
    input  logic                      is_unsigned,
    output logic [XLEN-1:0]           result
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] top;
    logic            sign;
    int unsigned     nbits;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SZ_BYTE: nbits = 8;
            SZ_HALF: nbits = 16;
            SZ_WORD: nbits = 32;
            default: nbits = 64;
        endcase
        if (nbits > XLEN) nbits = XLEN;
        // A full-width shift yields 0, so keep becomes all ones for size == XLEN.
        keep   = (XLEN'(1) << nbits) - XLEN'(1);
        top    = keep ^ (keep >> 1);
        sign   = !is_unsigned && (|(shifted & top));
        result = (shifted & keep) | (sign ? ~keep : '0);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request port and a data memory.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses fail without a bus access.
//
// state   | meaning
// IDLE    | ready for a core request
// REQ     | memory request presented, waiting for i_dm_ready
// WAIT_R  | load accepted by memory, waiting for i_dm_rvalid
// RSP     | one-cycle response to the core
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_rsp_valid,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [XLEN-1:0]   o_dm_addr,
    output logic              o_dm_valid,
    output logic              o_dm_we,
    output logic [XLEN/8-1:0] o_dm_wstrb,
    output logic [XLEN-1:0]   o_dm_wdata,
    input  logic              i_dm_ready,
    input  logic              i_dm_rvalid,
    input  logic [XLEN-1:0]   i_dm_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(WAIT_MAX + 1);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("load_store_unit: XLEN must be 32 or 64");
    end

    lsu_state_e      state_q, state_d;
    lsu_size_e       size_q, size_in;
    logic            we_q, uns_q, err_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] low_mask_in, load_result;
    logic            skip_in, last_wait, timeout, in_req, in_rsp;

    assign size_in     = lsu_size_e'(i_req_size);
    assign low_mask_in = XLEN'(size_low_bits(size_in));
    assign last_wait   = (cnt_q == CW'(WAIT_MAX - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign skip_in = ((XLEN == 32) && (size_in == SZ_DOUBLE)) || (|(i_req_addr & low_mask_in));
`else
    assign skip_in = (XLEN == 32) && (size_in == SZ_DOUBLE);
`endif

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) state_d = skip_in ? ST_RSP : ST_REQ;
            end
            ST_REQ: begin
                if (i_dm_ready) begin
                    state_d = we_q ? ST_RSP : ST_WAIT_R;
                end else if (last_wait) begin
                    state_d = ST_RSP;
                    timeout = 1'b1;
                end
            end
            ST_WAIT_R: begin
                if (i_dm_rvalid) begin
                    state_d = ST_RSP;
                end else if (last_wait) begin
                    state_d = ST_RSP;
                    timeout = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            size_q  <= SZ_BYTE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        we_q    <= i_req_we;
                        uns_q   <= i_req_unsigned;
                        size_q  <= size_in;
                        addr_q  <= i_req_addr & ~low_mask_in;
                        wdata_q <= i_req_wdata;
                        rdata_q <= '0;
                        err_q   <= skip_in;
                        cnt_q   <= '0;
                    end
                end
                ST_REQ: begin
                    cnt_q <= (state_d == ST_WAIT_R) ? '0 : cnt_q + CW'(1);
                    if (timeout) err_q <= 1'b1;
                end
                ST_WAIT_R: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (i_dm_rvalid) rdata_q <= i_dm_rdata;
                    if (timeout) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata       (rdata_q),
        .offset      (addr_q[OFFW-1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (load_result)
    );

    assign in_req = (state_q == ST_REQ);
    assign in_rsp = (state_q == ST_RSP);

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_dm_valid  = in_req;
    assign o_dm_we     = in_req && we_q;
    assign o_dm_addr   = in_req ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
    // Store lane steering: byte enables and data move up by the byte offset.
    assign o_dm_wstrb  = in_req ? (NB'(size_mask(size_q)) << addr_q[OFFW-1:0]) : '0;
    assign o_dm_wdata  = in_req ? (wdata_q << {addr_q[OFFW-1:0], 3'b000}) : '0;

    assign o_rsp_valid = in_rsp;
    assign o_rsp_err   = in_rsp && err_q;
    assign o_rsp_rdata = (in_rsp && !err_q && !we_q) ? load_result : '0;

endmodule
